// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: latches two operands and a carry-in, then adds them LSB first
// through a single full-adder cell, one bit per clock, ending with a one-cycle done pulse.
module serial_adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic majority3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] a_r, b_r, res_r, sum_r;
  logic [WIDTH-1:0] a_nxt_s, b_nxt_s, res_nxt_s, sum_nxt_s;
  logic             c_r, carry_r, busy_r, done_r;
  logic             c_nxt_s, carry_nxt_s, busy_nxt_s, done_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             fa_sum_s, fa_carry_s, last_bit_s;

  assign fa_sum_s   = a_r[0] ^ b_r[0] ^ c_r;
  assign fa_carry_s = majority3(a_r[0], b_r[0], c_r);
  assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_bit_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and output next values; done defaults low so it only pulses
  always_comb begin
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    c_nxt_s     = c_r;
    res_nxt_s   = res_r;
    cnt_nxt_s   = cnt_r;
    sum_nxt_s   = sum_r;
    carry_nxt_s = carry_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          a_nxt_s    = i_op1;
          b_nxt_s    = i_op2;
          c_nxt_s    = i_carry;
          res_nxt_s  = {WIDTH{1'b0}};
          cnt_nxt_s  = {CW{1'b0}};
          busy_nxt_s = 1'b1;
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      SHIFT: begin
        a_nxt_s   = {1'b0, a_r[WIDTH-1:1]};
        b_nxt_s   = {1'b0, b_r[WIDTH-1:1]};
        c_nxt_s   = fa_carry_s;
        res_nxt_s = {fa_sum_s, res_r[WIDTH-1:1]};
        cnt_nxt_s = cnt_r + CW'(1);
        if (last_bit_s) begin
          sum_nxt_s   = {fa_sum_s, res_r[WIDTH-1:1]};
          carry_nxt_s = fa_carry_s;
          done_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b0;
        end else begin
          busy_nxt_s  = 1'b1;
        end
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      c_r     <= 1'b0;
      res_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      c_r     <= c_nxt_s;
      res_r   <= res_nxt_s;
      cnt_r   <= cnt_nxt_s;
      sum_r   <= sum_nxt_s;
      carry_r <= carry_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign o_sum   = sum_r;
  assign o_carry = carry_r;
  assign o_busy  = busy_r;
  assign o_done  = done_r;

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Self-checking bench for serial_adder_4bit: directed cases, random operations with
// noise on the inputs while busy, and an exhaustive back-to-back sweep against op1+op2+cin.
module tb_serial_adder_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         carry_in;
  logic [W-1:0] op1, op2;
  logic [W-1:0] sum;
  logic         carry_out, busy, done;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] hold_sum;
  logic         hold_carry;

  serial_adder_4bit #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_op1   (op1),
    .i_op2   (op2),
    .i_carry (carry_in),
    .o_sum   (sum),
    .o_carry (carry_out),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // mode 0: quiet while busy, 1: random noise while busy, 2: start held with 15/15/1
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int mode);
    logic [W:0] exp;
    int k;
    bit seen;
    exp = a + b + ci;
    start = 1'b1; op1 = a; op2 = b; carry_in = ci;
    @(negedge clk);
    k = 1;
    seen = 1'b0;
    while (k <= 20 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        check_eq("busy_high", busy, 1);
        check_eq("sum_held", sum, hold_sum);
        check_eq("carry_held", carry_out, hold_carry);
        case (mode)
          1: begin
            start = 1'($urandom); op1 = W'($urandom); op2 = W'($urandom); carry_in = 1'($urandom);
          end
          2: begin
            start = 1'b1; op1 = 4'd15; op2 = 4'd15; carry_in = 1'b1;
          end
          default: start = 1'b0;
        endcase
        @(negedge clk);
        k++;
      end
    end
    if (!seen) begin
      check_eq("done_timeout", done, 1);
    end else begin
      check_eq("latency", k, W + 1);
      check_eq("sum", sum, exp[W-1:0]);
      check_eq("carry", carry_out, exp[W]);
      check_eq("busy_low_at_done", busy, 0);
    end
    hold_sum   = exp[W-1:0];
    hold_carry = exp[W];
  endtask

  task automatic idle_cycles(input int n, input string tag);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq(tag, done, 0);
      check_eq("idle_busy", busy, 0);
    end
    check_eq("idle_sum", sum, hold_sum);
    check_eq("idle_carry", carry_out, hold_carry);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op1 = 4'd0; op2 = 4'd0; carry_in = 1'b0;
    hold_sum = 4'd0; hold_carry = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(10, "reset_idle_done");

    run_op(4'd9, 4'd5, 1'b0, 0);
    idle_cycles(3, "single_hold_done");
    run_op(4'd15, 4'd15, 1'b1, 0);
    start = 1'b0;
    check_eq("ovf_sum", sum, 15);
    check_eq("ovf_carry", carry_out, 1);
    run_op(4'd8, 4'd8, 1'b0, 0);
    start = 1'b0;
    check_eq("wrap_sum", sum, 0);
    check_eq("wrap_carry", carry_out, 1);

    run_op(4'd3, 4'd4, 1'b0, 2);
    start = 1'b0;
    idle_cycles(8, "ignored_no_second_done");

    start = 1'b1; op1 = 4'd6; op2 = 4'd7; carry_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_done", done, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_sum", sum, 0);
    check_eq("abort_carry", carry_out, 0);
    rst_n = 1'b1;
    hold_sum = 4'd0; hold_carry = 1'b0;
    idle_cycles(6, "abort_no_done");
    run_op(4'd6, 4'd7, 1'b0, 0);
    start = 1'b0;
    check_eq("after_abort_sum", sum, 13);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1);
    end
    start = 1'b0;
    @(negedge clk);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          run_op(W'(a), W'(b), 1'(c), 0);
        end
      end
    end
    start = 1'b0;
    idle_cycles(3, "final_idle_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
